// File: rtl/dpram_fifo_pkg.sv
// Shared sizing helpers for dpram_fifo: capacity from address width and the
// width of the occupancy/free-space counters.
package dpram_fifo_pkg;

  function automatic int fifo_size(input int aw);
    return 1 << aw;
  endfunction

  function automatic int lvl_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with
// read enable and a synchronous clear of the output register only.
module fifo_ram
  import dpram_fifo_pkg::*;
#(
  parameter int width = 16,
  parameter int size  = 16,
  localparam int AW   = $clog2(size)
) (
  input  logic             clock_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [width-1:0] rdata_o
);

  logic [width-1:0] mem_q [size];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clock_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a full FIFO reading and writing the same slot gets the old word.
  always_ff @(posedge clock_i) begin
    if (clr_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dpram_fifo.sv
// Single-clock FIFO over fifo_ram: pointers, occupancy, full/empty, valid strobe.
// Optional sticky overflow/underflow flags via `define DPRAM_FIFO_ERRFLAGS_EN.
module dpram_fifo
  import dpram_fifo_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 4,
  parameter int size  = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic [width-1:0] datain_i,
  input  logic             write_i,
  output logic             full_o,
  input  logic             read_i,
  output logic [width-1:0] dataout_o,
  output logic             valid_o,
  output logic             empty_o,
  output logic [depth:0]   level_o,
  output logic [depth:0]   space_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int LW = lvl_width(depth);
  localparam logic [LW-1:0] FULL_LVL = LW'(fifo_size(depth));

  logic [depth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             valid_q, valid_d;
  logic             flush, full, empty, wr_ok, rd_ok;

  assign flush = reset_i | clear_i;
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  // No bypass: on an empty FIFO a same-cycle read is rejected.
  assign rd_ok = read_i & ~empty;
  assign wr_ok = write_i & (~full | read_i);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    valid_d = rd_ok;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  end

  fifo_ram #(
    .width (width),
    .size  (size)
  ) u_ram (
    .clock_i (clock_i),
    .clr_i   (flush),
    .we_i    (wr_ok & ~flush),
    .waddr_i (wptr_q),
    .wdata_i (datain_i),
    .re_i    (rd_ok & ~flush),
    .raddr_i (rptr_q),
    .rdata_o (dataout_o)
  );

  assign full_o  = full;
  assign empty_o = empty;
  assign valid_o = valid_q;
  assign level_o = level_q;
  assign space_o = FULL_LVL - level_q;

`ifdef DPRAM_FIFO_ERRFLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clock_i) begin
    if (flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (write_i & ~wr_ok) ovf_q <= 1'b1;
      if (read_i & ~rd_ok)  unf_q <= 1'b1;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo.sv
// Self-checking bench for dpram_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model, compared after every clock edge.
module tb_dpram_fifo;

  logic        clock, reset, clear, write, read;
  logic [15:0] datain, dataout;
  logic        full, empty, valid, overflow, underflow;
  logic [4:0]  level, space;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] mq[$];
  logic [15:0] m_dout;
  logic        m_valid, m_ovf, m_unf;

  dpram_fifo #(.width(16), .depth(4), .size(16)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .clear_i     (clear),
    .datain_i    (datain),
    .write_i     (write),
    .full_o      (full),
    .read_i      (read),
    .dataout_o   (dataout),
    .valid_o     (valid),
    .empty_o     (empty),
    .level_o     (level),
    .space_o     (space),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: applies one clock edge's worth of the FIFO rules.
  task automatic model_edge(input logic rst, clr, wr, rd, input logic [15:0] d);
    bit was_full, was_empty, rd_acc, wr_acc;
    if (rst || clr) begin
      mq.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      was_full  = (mq.size() == 16);
      was_empty = (mq.size() == 0);
      rd_acc = rd && !was_empty;
      wr_acc = wr && (!was_full || rd_acc);
      m_valid = rd_acc;
      if (rd_acc) m_dout = mq.pop_front();
      if (wr_acc) mq.push_back(d);
`ifdef DPRAM_FIFO_ERRFLAGS_EN
      if (wr && !wr_acc) m_ovf = 1'b1;
      if (rd && !rd_acc) m_unf = 1'b1;
`endif
    end
  endtask

  task automatic compare_all();
    chk("level",     int'(level),     mq.size());
    chk("space",     int'(space),     16 - mq.size());
    chk("full",      int'(full),      int'(mq.size() == 16));
    chk("empty",     int'(empty),     int'(mq.size() == 0));
    chk("valid",     int'(valid),     int'(m_valid));
    chk("dataout",   int'(dataout),   int'(m_dout));
    chk("overflow",  int'(overflow),  int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
  endtask

  task automatic cyc(input logic rst, clr, wr, rd, input logic [15:0] d);
    reset = rst; clear = clr; write = wr; read = rd; datain = d;
    @(posedge clock);
    model_edge(rst, clr, wr, rd, d);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0; datain = '0;
    m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset
    cyc(1, 0, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_space", int'(space), 16);
    chk("rst_valid", int'(valid), 0);
    chk("rst_dataout", int'(dataout), 0);

    // Fill / drain
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 16'(i));
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 16);
    chk("fill_space", int'(space), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 16'h0);
      chk("drain_valid", int'(valid), 1);
      chk("drain_data", int'(dataout), i);
    end
    chk("drain_empty", int'(empty), 1);
    cyc(0, 0, 0, 0, 16'h0);
    chk("idle_valid", int'(valid), 0);
    chk("idle_hold", int'(dataout), 16'h000F);

    // Wrap-around
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 16'hA000 + 16'(i));
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1, 16'h0);
      chk("wrap1_data", int'(dataout), 16'hA000 + i);
    end
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0, 16'hA000 + 16'(i));
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 1, 16'h0);
      chk("wrap2_data", int'(dataout), 16'hA000 + i);
    end
    chk("wrap_level", int'(level), 0);

    // Simultaneous at full
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 16'hC000 + 16'(i));
    cyc(0, 0, 1, 1, 16'hBEEF);
    chk("full_rw_level", int'(level), 16);
    chk("full_rw_data", int'(dataout), 16'hC000);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 0, 1, 16'h0);
      chk("full_rw_old", int'(dataout), 16'hC000 + i);
    end
    cyc(0, 0, 0, 1, 16'h0);
    chk("full_rw_beef", int'(dataout), 16'hBEEF);

    // Simultaneous at empty
    cyc(0, 0, 1, 1, 16'h1234);
    chk("empty_rw_level", int'(level), 1);
    chk("empty_rw_valid", int'(valid), 0);
    cyc(0, 0, 0, 1, 16'h0);
    chk("empty_rw_data", int'(dataout), 16'h1234);

    // Error flags (model expects zero when the feature is compiled out)
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 16'(i));
    cyc(0, 0, 1, 0, 16'hDEAD);
    chk("ovf_level", int'(level), 16);
`ifdef DPRAM_FIFO_ERRFLAGS_EN
    chk("ovf_set", int'(overflow), 1);
`endif
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 16'h0);
    cyc(0, 0, 0, 1, 16'h0);
`ifdef DPRAM_FIFO_ERRFLAGS_EN
    chk("unf_set", int'(underflow), 1);
`endif
    cyc(0, 1, 0, 0, 16'h0);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_unf", int'(underflow), 0);
    chk("clr_empty", int'(empty), 1);

    // Mid-operation clear
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 16'h7000 + 16'(i));
    chk("pre_clr_level", int'(level), 7);
    cyc(0, 1, 1, 1, 16'hFFFF);
    chk("mclr_level", int'(level), 0);
    chk("mclr_empty", int'(empty), 1);
    chk("mclr_valid", int'(valid), 0);
    cyc(0, 0, 1, 0, 16'h5555);
    cyc(0, 0, 0, 1, 16'h0);
    chk("mclr_data", int'(dataout), 16'h5555);
    chk("mclr_dvalid", int'(valid), 1);

    // Randomized traffic with shifting write/read bias
    for (int ph = 0; ph < 12; ph++) begin
      int wp, rp;
      wp = $urandom_range(10, 95);
      rp = $urandom_range(10, 95);
      for (int k = 0; k < 250; k++) begin
        logic r_rst, r_clr, r_wr, r_rd;
        r_rst = ($urandom_range(0, 199) == 0);
        r_clr = ($urandom_range(0, 149) == 0);
        r_wr  = ($urandom_range(0, 99) < wp);
        r_rd  = ($urandom_range(0, 99) < rp);
        cyc(r_rst, r_clr, r_wr, r_rd, 16'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
